// File: rtl/fifo_axis_pkg.sv
// fifo_axis_pkg: shared constants and types for the FIFO-to-AXI4-Stream drain stage.
package fifo_axis_pkg;
   localparam int DATA_W_DEF    = 8;
   localparam int BURST_LEN_DEF = 4;
   localparam int OCC_W         = 2;
   localparam int PKT_CNT_W     = 16;
   typedef logic [OCC_W-1:0] occ_t;
endpackage

// File: rtl/axis_out_buf.sv
// axis_out_buf: 2-entry ordered buffer; head is a register so it can drive tdata directly.
module axis_out_buf import fifo_axis_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] data,
   input  logic              pop,
   output occ_t              occ,
   output logic [DATA_W-1:0] head
);
   logic [DATA_W-1:0] tail;
   occ_t keep;
   // entries surviving the pop; a pushed word lands right behind them
   assign keep = occ - occ_t'(pop);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         occ  <= '0;
         head <= '0;
         tail <= '0;
      end else begin
         occ  <= keep + occ_t'(push);
         head <= (push && keep == occ_t'(0)) ? data : pop ? tail : head;
         tail <= (push && keep == occ_t'(1)) ? data : tail;
      end
endmodule

// File: rtl/fifo_axis_master.sv
// fifo_axis_master: drains a registered-read FIFO into an AXI4-Stream master with tlast every BURST_LEN beats.
// Define FIFO_AXIS_STATS_EN to add the pkt_count output counting completed packets.
module fifo_axis_master import fifo_axis_pkg::*; #(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_empty,
   output logic                 fifo_read,
   input  logic [DATA_W-1:0]    fifo_data,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [DATA_W-1:0]    m_axis_tdata,
   output logic                 m_axis_tlast,
`ifdef FIFO_AXIS_STATS_EN
   output logic [PKT_CNT_W-1:0] pkt_count,
`endif
   output logic                 idle
);
   localparam int CNT_W = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
   occ_t occ;
   logic inflight, pop, last_cnt;
   logic [CNT_W-1:0] beat_cnt;
   logic [2:0] pend;
   assign pop = m_axis_tvalid & m_axis_tready;
   // words owned after this edge; issuing only below 2 keeps the buffer from overflowing
   assign pend = 3'(occ) + 3'(inflight) - 3'(pop);
   assign fifo_read = !reset && !fifo_empty && pend < 3'd2;
   assign m_axis_tvalid = occ != '0;
   assign last_cnt = beat_cnt == CNT_W'(BURST_LEN - 1);
   assign m_axis_tlast = last_cnt & m_axis_tvalid;
   assign idle = occ == '0 && !inflight && fifo_empty;
   axis_out_buf #(.DATA_W(DATA_W)) u_buf (
      .clk  (clk),
      .reset(reset),
      .push (inflight),
      .data (fifo_data),
      .pop  (pop),
      .occ  (occ),
      .head (m_axis_tdata)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         inflight <= 1'b0;
         beat_cnt <= '0;
      end else begin
         inflight <= fifo_read;
         beat_cnt <= pop ? (last_cnt ? '0 : beat_cnt + 1'b1) : beat_cnt;
      end
`ifdef FIFO_AXIS_STATS_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) pkt_count <= '0;
      else if (pop && m_axis_tlast) pkt_count <= pkt_count + 1'b1;
`endif
endmodule

// File: tb/tb_fifo_axis_master.sv
// tb_fifo_axis_master: randomized scoreboard bench with a queue-based FIFO model and reference beat framing.
module tb_fifo_axis_master;
   localparam int W  = 8;
   localparam int BL = 4;
   logic clk = 0, reset = 1;
   always #5 clk = ~clk;
   logic fifo_empty = 1, fifo_read, tvalid, tready = 0, tlast, idle;
   logic [W-1:0] fifo_data = '0, tdata;
   logic e1 = 0, rd1, v1, r1 = 0, l1, idle1;
   logic [W-1:0] d1 = '0, td1;
`ifdef FIFO_AXIS_STATS_EN
   logic [15:0] pkt_count, pkt1;
`endif
   fifo_axis_master #(.DATA_W(W), .BURST_LEN(BL)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read(fifo_read), .fifo_data(fifo_data),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
`ifdef FIFO_AXIS_STATS_EN
      .pkt_count(pkt_count),
`endif
      .idle(idle));
   fifo_axis_master #(.DATA_W(W), .BURST_LEN(1)) dut1 (
      .clk(clk), .reset(reset), .fifo_empty(e1), .fifo_read(rd1), .fifo_data(d1),
      .m_axis_tvalid(v1), .m_axis_tready(r1), .m_axis_tdata(td1), .m_axis_tlast(l1),
`ifdef FIFO_AXIS_STATS_EN
      .pkt_count(pkt1),
`endif
      .idle(idle1));
   int total = 0, bad = 0, beat_idx = 0, pkts = 0;
   logic [W-1:0] fq[$], exp_q[$], q1[$];
   logic [W-1:0] src1 = '0;
   logic pv = 0, pr = 0;
   logic [W-1:0] pd = '0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask
   // FIFO_buffer model: registered read, each popped word becomes an expected beat
   always @(posedge clk) begin
      if (fifo_read) begin
         total++;
         if (fq.size() == 0) begin
            bad++;
            $display("FAIL read_empty: got read with empty fifo want no read at %0t", $time);
         end else begin
            fifo_data <= fq[0];
            exp_q.push_back(fq[0]);
            void'(fq.pop_front());
         end
      end
      fifo_empty <= fq.size() == 0;
      if (rd1) begin
         d1 <= src1;
         q1.push_back(src1);
         src1 <= src1 + 1'b1;
      end
   end
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         q1.delete();
         beat_idx = 0;
         pkts = 0;
         pv = 0;
      end else begin
         if (pv && !pr) begin
            chk("hold_valid", 32'(tvalid), 1);
            chk("hold_data", 32'(tdata), 32'(pd));
         end
`ifdef FIFO_AXIS_STATS_EN
         chk("pkt_count", 32'(pkt_count), 32'(pkts % 65536));
`endif
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat: got tdata %0h want no beat", tdata);
            end else begin
               chk("tdata", 32'(tdata), 32'(exp_q.pop_front()));
               chk("tlast", 32'(tlast), 32'(beat_idx % BL == BL - 1));
            end
            if (beat_idx % BL == BL - 1) pkts++;
            beat_idx++;
         end
         pv = tvalid;
         pr = tready;
         pd = tdata;
         if (v1 && r1) begin
            if (q1.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat1: got tdata %0h want no beat", td1);
            end else chk("tdata1", 32'(td1), 32'(q1.pop_front()));
            chk("tlast1", 32'(l1), 1);
         end
      end
   end
   always begin
      @(posedge clk);
      #1 r1 = !r1;
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic rst_check;
      chk("rst_tvalid", 32'(tvalid), 0);
      chk("rst_fifo_read", 32'(fifo_read), 0);
      chk("rst_tlast", 32'(tlast), 0);
      chk("rst_tdata", 32'(tdata), 0);
      chk("rst_tvalid1", 32'(v1), 0);
   endtask
   task automatic do_reset;
      reset = 1;
      #1 rst_check();
      repeat (2) tick();
      reset = 0;
   endtask
   task automatic wait_idle(input string name);
      int n = 0;
      tready = 1;
      repeat (2) tick();
      while (!idle && n < 200) begin
         tick();
         n++;
      end
      chk(name, 32'(idle), 1);
   endtask
   logic [W-1:0] stream [8] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'h55, 8'h6C, 8'h10, 8'h01};
   initial begin
      int n;
      repeat (3) tick();
      rst_check();
      reset = 0;
      chk("idle_after_reset", 32'(idle), 1);
      tick();
      tready = 1;
      foreach (stream[i]) fq.push_back(stream[i]);
      n = 0;
      while (!fifo_read && n < 10) begin
         tick();
         n++;
      end
      chk("first_read", 32'(fifo_read), 1);
      tick();
      chk("lat_cycle1_tvalid", 32'(tvalid), 0);
      tick();
      chk("lat_cycle2_tvalid", 32'(tvalid), 1);
      repeat (7) begin
         tick();
         chk("stream_tvalid", 32'(tvalid), 1);
      end
      tick();
      chk("stream_end_tvalid", 32'(tvalid), 0);
      chk("stream_end_idle", 32'(idle), 1);
      repeat (8) fq.push_back(W'($urandom));
      repeat (4) tick();
      tready = 0;
      repeat (3) tick();
      chk("bp_fifo_read", 32'(fifo_read), 0);
      chk("bp_tvalid", 32'(tvalid), 1);
      repeat (2) tick();
      wait_idle("bp_drain_idle");
      fq.push_back(8'h81);
      wait_idle("drain_idle");
      chk("drain_tvalid", 32'(tvalid), 0);
      fq.push_back(8'h81);
      fq.push_back(8'h80);
      wait_idle("refill_idle");
      tready = 0;
      repeat (3) fq.push_back(W'($urandom));
      repeat (6) tick();
      chk("pre_rst_tvalid", 32'(tvalid), 1);
      chk("pre_rst_fifo_read", 32'(fifo_read), 0);
      do_reset();
      repeat (4) fq.push_back(W'($urandom));
      wait_idle("post_rst_idle");
      repeat (3000) begin
         tick();
         tready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 1) == 1) fq.push_back(W'($urandom));
         if ($urandom_range(0, 999) == 0) do_reset();
      end
      wait_idle("final_idle");
      chk("final_exp_empty", 32'(exp_q.size()), 0);
      chk("final_fifo_empty", 32'(fq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_axis_master.md
Name: fifo_axis_master

Overview:
- Read-side drain stage placed directly downstream of FIFO_buffer.
- Pops words from the FIFO read port (registered read, 1-cycle latency) and presents them as an AXI4-Stream master.
- A 2-entry output buffer absorbs the FIFO read latency, so the stream sustains one beat per clock under continuous tready.
- Generates tlast every BURST_LEN beats to frame fixed-length packets for downstream AXI4 consumers.

Parameters:
- DATA_W, 8, width of FIFO data and m_axis_tdata.
- BURST_LEN, 4, beats per packet; tlast is asserted on the last beat; must be >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO has no readable word.
- fifo_read  output  1  pop strobe to the FIFO "read" input.
- fifo_data  input  DATA_W  FIFO output word, valid the cycle after fifo_read is sampled high.
- m_axis_tvalid  output  1  stream beat valid.
- m_axis_tready  input  1  downstream accepts beat.
- m_axis_tdata  output  DATA_W  stream payload.
- m_axis_tlast  output  1  last beat of a BURST_LEN packet.
- idle  output  1  high when buffer is empty, no read is in flight, and fifo_empty=1.

Behaviour:
- Reset (async assert, sync release effect):
  - occ=0, inflight=0, beat_cnt=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - fifo_read forced 0 while reset is high.
- State:
  - occ: 0..2 entries held in the buffer.
  - inflight: 1 bit, a read issued last cycle whose data lands this cycle.
  - beat_cnt: 0..BURST_LEN-1.
- pop = m_axis_tvalid & m_axis_tready.
- fifo_read = !reset & !fifo_empty & ((occ + inflight - pop) < 2).
  - Combinational path from tready to fifo_read is permitted.
  - This guarantees the buffer never overflows.
- Capture: when inflight=1, fifo_data is written to the buffer tail this cycle. inflight_next = fifo_read.
- occ_next = occ + inflight - pop. Simultaneous capture and pop when occ=1 keeps occ=1; the head advances to the new word.
- m_axis_tvalid = (occ != 0). m_axis_tdata = head entry, registered.
- AXI rules:
  - Once tvalid=1, tvalid and tdata are held stable until pop.
  - tvalid never depends on tready.
  - Beat order equals FIFO pop order.
- tlast = (beat_cnt == BURST_LEN-1) & m_axis_tvalid.
  - beat_cnt increments on pop and wraps to 0 after the tlast beat.
  - BURST_LEN=1: tlast is high on every beat.
- Latency: FIFO non-empty at edge N gives fifo_read high in cycle N, data captured at N+1, tvalid high from cycle N+2.
- Throughput: 1 beat/clk while the FIFO is non-empty and tready=1.
- Boundary cases:
  - fifo_empty=1: no reads; the buffer drains; tvalid falls after the last pop.
  - tready=0 with occ=2: fifo_read=0.
  - tready low for one cycle: no beat is lost or duplicated.
  - Reset mid-packet: buffer contents and in-flight word are discarded, beat_cnt=0, and the next beat starts a new packet.
- idle = (occ==0) & !inflight & fifo_empty.

Optional Feature:
- Macro FIFO_AXIS_STATS_EN.
- Defined: adds output pkt_count [15:0], reset 0.
  - Increments on every pop with tlast=1.
  - Wraps 0xFFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fifo_axis_pkg: default DATA_W, default BURST_LEN, OCC_W=2 constant, occupancy typedef, PKT_CNT_W=16.
- Sub-module axis_out_buf: 2-entry ordered buffer with push/pop/occ/head.
- fifo_axis_master holds the read-issue logic, inflight flag, and beat counter.

Test Plan:
- Reset: assert reset mid-stream with occ=2 -> tvalid=0, fifo_read=0, tlast=0 immediately; after release the first beat has beat_cnt=0.
- Streaming: FIFO preloaded FF,00,F0,0F,55,6C,10,01 with tready=1 -> beats in that order on consecutive cycles starting 2 cycles after the first read; tlast on 0F and 01.
- Backpressure: tready=0 for 5 cycles mid-stream -> fifo_read stops after occ=2; tdata held stable; order preserved on resume; no word lost.
- Drain and refill: FIFO goes empty after 81 -> tvalid drops after the 81 beat and idle=1; a later write of 81,80 is emitted with beat_cnt continuing from its prior value.
- Alternating tready 1/0 with BURST_LEN=1 -> tlast on every beat; no duplicates.
- With FIFO_AXIS_STATS_EN: 3 full packets -> pkt_count=3; preset to 0xFFFF then one packet -> 0.
